// File: rtl/cpu_bus_pkg.sv
// Shared widths, debug state type and a sizing helper for the 65C02 bus controller.
package cpu_bus_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   typedef enum logic {
      RUN  = 1'b0,
      WAIT = 1'b1
   } bus_state_t;

   // Width of a binary slot index; a single slot still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side and slot-side signal bundle of the bus controller.
interface cpu_bus_ctrl_if
   import cpu_bus_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int WAIT_BITS = 3
);

   logic [ADDR_W-1:0]           addr_next;
   logic [DATA_W-1:0]           dout_next;
   logic                        we_next;
   logic [ADDR_W*NUM_SLOTS-1:0] slot_base;
   logic [ADDR_W*NUM_SLOTS-1:0] slot_mask;
   logic [WAIT_BITS*NUM_SLOTS-1:0] slot_wait;
   logic [DATA_W*NUM_SLOTS-1:0] slot_din;
   logic [DATA_W-1:0]           ext_din;

   logic                        cpu_rdy;
   logic [DATA_W-1:0]           cpu_din;
   logic [ADDR_W-1:0]           bus_addr;
   logic [DATA_W-1:0]           bus_dout;
   logic                        bus_we;
   logic [NUM_SLOTS-1:0]        slot_sel;
   logic [NUM_SLOTS-1:0]        slot_cs;
   logic                        ext_sel;
   logic                        phi2;

   modport slave (
      input  addr_next, dout_next, we_next,
      input  slot_base, slot_mask, slot_wait, slot_din, ext_din,
      output cpu_rdy, cpu_din, bus_addr, bus_dout, bus_we,
      output slot_sel, slot_cs, ext_sel, phi2
   );

   modport master (
      output addr_next, dout_next, we_next,
      output slot_base, slot_mask, slot_wait, slot_din, ext_din,
      input  cpu_rdy, cpu_din, bus_addr, bus_dout, bus_we,
      input  slot_sel, slot_cs, ext_sel, phi2
   );

endinterface

// File: rtl/cpu_bus_decode.sv
// Programmable window decoder: base/mask compare per slot, lowest index wins.
module cpu_bus_decode
   import cpu_bus_pkg::*;
#(
   parameter int NUM_SLOTS = 4
)(
   input  logic [ADDR_W-1:0]                addr,
   input  logic [ADDR_W*NUM_SLOTS-1:0]      bases,
   input  logic [ADDR_W*NUM_SLOTS-1:0]      masks,
   output logic [NUM_SLOTS-1:0]             sel,
   output logic [idx_width(NUM_SLOTS)-1:0]  idx,
   output logic                             hit
);

   localparam int IDX_W = idx_width(NUM_SLOTS);

   logic [NUM_SLOTS-1:0] hits;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_win
         logic [ADDR_W-1:0] mask_w;
         assign mask_w   = masks[gi*ADDR_W +: ADDR_W];
         assign hits[gi] = ((addr & mask_w) == (bases[gi*ADDR_W +: ADDR_W] & mask_w));
      end
   endgenerate

   // x & -x keeps only the lowest set bit, which gives lowest-index priority
   assign sel = hits & (~hits + NUM_SLOTS'(1));
   assign hit = |hits;

   always_comb begin
      idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (hits[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// 65C02 bus controller: RDY clock enable, output registers, slot decode, wait states, read mux.
module cpu_bus_ctrl
   import cpu_bus_pkg::*;
#(
   parameter int CLKEN_BITS = 2,
   parameter int NUM_SLOTS  = 4,
   parameter int WAIT_BITS  = 3
)(
   input  logic          clk,
   input  logic          resb,
   cpu_bus_ctrl_if.slave bus
);

   localparam int IDX_W = idx_width(NUM_SLOTS);

   logic [CLKEN_BITS-1:0] ctr_reg;
   logic                  tick;
   logic                  rdy_reg;
   logic                  rdy_next;
   logic [WAIT_BITS-1:0]  wcnt_reg;
   logic [WAIT_BITS-1:0]  wcnt_next;
   logic [WAIT_BITS-1:0]  wait_load;
   logic [ADDR_W-1:0]     addr_reg;
   logic [DATA_W-1:0]     dout_reg;
   logic                  we_reg;
   bus_state_t            state;

   logic [NUM_SLOTS-1:0]  sel_next;
   logic [NUM_SLOTS-1:0]  sel_cur;
   logic [IDX_W-1:0]      idx_next;
   logic [IDX_W-1:0]      idx_cur;
   logic                  hit_next;
   logic                  hit_cur;

   // Decode of the early address sizes the wait of the access about to start
   cpu_bus_decode #(.NUM_SLOTS(NUM_SLOTS)) u_dec_next (
      .addr  (bus.addr_next),
      .bases (bus.slot_base),
      .masks (bus.slot_mask),
      .sel   (sel_next),
      .idx   (idx_next),
      .hit   (hit_next)
   );

   cpu_bus_decode #(.NUM_SLOTS(NUM_SLOTS)) u_dec_cur (
      .addr  (addr_reg),
      .bases (bus.slot_base),
      .masks (bus.slot_mask),
      .sel   (sel_cur),
      .idx   (idx_cur),
      .hit   (hit_cur)
   );

   assign tick      = &ctr_reg;
   assign wait_load = (hit_next && sel_next[idx_next])
                    ? bus.slot_wait[idx_next*WAIT_BITS +: WAIT_BITS]
                    : '0;

   always_comb begin
      state     = (wcnt_reg == '0) ? RUN : WAIT;
      rdy_next  = 1'b0;
      wcnt_next = wcnt_reg;
      // rdy only occurs with ctr==0, so an access start never meets a tick
      if (rdy_reg) begin
         wcnt_next = wait_load;
      end else begin
         case (state)
            RUN:     rdy_next = tick;
            WAIT:    if (tick) wcnt_next = wcnt_reg - WAIT_BITS'(1);
            default: rdy_next = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resb) begin
      if (!resb) begin
         ctr_reg  <= '0;
         rdy_reg  <= 1'b0;
         wcnt_reg <= '0;
         addr_reg <= '0;
         dout_reg <= '0;
         we_reg   <= 1'b0;
      end else begin
         ctr_reg  <= ctr_reg + CLKEN_BITS'(1);
         rdy_reg  <= rdy_next;
         wcnt_reg <= wcnt_next;
         if (rdy_reg) begin
            addr_reg <= bus.addr_next;
            dout_reg <= bus.dout_next;
            we_reg   <= bus.we_next;
         end
      end
   end

   assign bus.cpu_rdy  = rdy_reg;
   assign bus.bus_addr = addr_reg;
   assign bus.bus_dout = dout_reg;
   assign bus.bus_we   = we_reg;
   assign bus.phi2     = ctr_reg[CLKEN_BITS-1];
   assign bus.slot_sel = sel_cur;
   assign bus.slot_cs  = sel_cur & {NUM_SLOTS{rdy_reg}};
   assign bus.ext_sel  = ~hit_cur;
   assign bus.cpu_din  = hit_cur ? bus.slot_din[idx_cur*DATA_W +: DATA_W] : bus.ext_din;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed scenarios plus randomized accesses vs. a timing model.
module tb_cpu_bus_ctrl;

   logic clk = 1'b0;
   logic resb;
   int   checks   = 0;
   int   failures = 0;

   logic [15:0] base [4];
   logic [15:0] mask [4];
   logic [2:0]  wt   [4];
   logic [7:0]  sdin [4];

   cpu_bus_ctrl_if #(.NUM_SLOTS(4), .WAIT_BITS(3)) bif ();

   assign bif.slot_base = {base[3], base[2], base[1], base[0]};
   assign bif.slot_mask = {mask[3], mask[2], mask[1], mask[0]};
   assign bif.slot_wait = {wt[3], wt[2], wt[1], wt[0]};
   assign bif.slot_din  = {sdin[3], sdin[2], sdin[1], sdin[0]};

   cpu_bus_ctrl #(.CLKEN_BITS(2), .NUM_SLOTS(4), .WAIT_BITS(3)) dut (
      .clk  (clk),
      .resb (resb),
      .bus  (bif.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference decode: first window (lowest index) whose masked base equals the masked address.
   function automatic int model_slot(input logic [15:0] a);
      for (int i = 0; i < 4; i++) begin
         if ((a & mask[i]) == (base[i] & mask[i])) return i;
      end
      return -1;
   endfunction

   // Called while cpu_rdy is high; runs one complete access and checks its completing cycle.
   task automatic do_access(input logic [15:0] a, input logic [7:0] d, input logic w, input string name);
      int s;
      int len;
      int waited;
      logic [3:0] exp_sel;
      logic [7:0] exp_din;
      waited = 0;
      while (bif.cpu_rdy !== 1'b1 && waited < 64) begin
         step();
         waited++;
      end
      chk({name, "_align"}, bif.cpu_rdy, 1);
      bif.addr_next = a;
      bif.dout_next = d;
      bif.we_next   = w;
      s   = model_slot(a);
      len = ((s < 0) ? 1 : (int'(wt[s]) + 1)) * 4;
      for (int k = 1; k <= len; k++) begin
         step();
         if (k == 1) begin
            bif.addr_next = 16'($urandom);
            bif.dout_next = 8'($urandom);
            bif.we_next   = 1'($urandom);
         end
         if (k < len) begin
            chk({name, "_rdy_lo"}, bif.cpu_rdy, 0);
            chk({name, "_cs_lo"}, bif.slot_cs, 0);
         end
      end
      exp_sel = (s < 0) ? 4'b0000 : (4'b0001 << s);
      exp_din = (s < 0) ? bif.ext_din : sdin[s];
      chk({name, "_rdy"}, bif.cpu_rdy, 1);
      chk({name, "_addr"}, bif.bus_addr, a);
      chk({name, "_dout"}, bif.bus_dout, d);
      chk({name, "_we"}, bif.bus_we, w);
      chk({name, "_sel"}, bif.slot_sel, exp_sel);
      chk({name, "_cs"}, bif.slot_cs, exp_sel);
      chk({name, "_ext"}, bif.ext_sel, (s < 0));
      chk({name, "_din"}, bif.cpu_din, exp_din);
      $display("access %s addr=%h dout=%h we=%b slot=%0d len=%0d", name, a, d, w, s, len);
   endtask

   initial begin
      logic [15:0] a;
      resb = 1'b0;
      base[0] = 16'h0000; mask[0] = 16'h8000; wt[0] = 3'd0;
      base[1] = 16'hC000; mask[1] = 16'hC000; wt[1] = 3'd0;
      base[2] = 16'h8000; mask[2] = 16'hFFF0; wt[2] = 3'd2;
      base[3] = 16'h8800; mask[3] = 16'hFFF0; wt[3] = 3'd0;
      for (int i = 0; i < 4; i++) sdin[i] = 8'h10 + 8'(i);
      bif.ext_din   = 8'hA5;
      bif.addr_next = 16'h1234;
      bif.dout_next = 8'h5A;
      bif.we_next   = 1'b1;

      repeat (3) step();
      chk("rst_rdy", bif.cpu_rdy, 0);
      chk("rst_phi2", bif.phi2, 0);
      chk("rst_addr", bif.bus_addr, 16'h0000);
      chk("rst_dout", bif.bus_dout, 8'h00);
      chk("rst_we", bif.bus_we, 0);
      chk("rst_cs", bif.slot_cs, 4'b0000);
      resb = 1'b1;

      // Free-running after release: rdy on clocks 4, 8, 12, 16; phi2 is ctr MSB
      for (int k = 1; k <= 16; k++) begin
         step();
         chk("fr_rdy", bif.cpu_rdy, (k % 4 == 0));
         chk("fr_phi2", bif.phi2, ((k % 4) >= 2));
         if (k == 4) chk("fr_first_cs", bif.slot_cs, 4'b0001);
         if (k == 5) chk("fr_addr", bif.bus_addr, 16'h1234);
      end

      do_access(16'h1234, 8'h5A, 1'b1, "wr1234");
      chk("wr1234_cs_slot0", bif.slot_cs, 4'b0001);

      sdin[2] = 8'h3C;
      do_access(16'h8003, 8'h00, 1'b0, "rd8003");
      chk("rd8003_sel", bif.slot_sel, 4'b0100);
      chk("rd8003_din", bif.cpu_din, 8'h3C);

      bif.ext_din = 8'hA5;
      do_access(16'h9000, 8'h00, 1'b0, "rd9000");
      chk("rd9000_ext", bif.ext_sel, 1);
      chk("rd9000_din", bif.cpu_din, 8'hA5);

      mask[0] = 16'h0000;
      do_access(16'hC010, 8'h77, 1'b0, "overlap");
      chk("overlap_sel", bif.slot_sel, 4'b0001);
      mask[0] = 16'h8000;

      wt[2] = 3'd7;
      do_access(16'h800F, 8'hE1, 1'b1, "maxwait");
      wt[2] = 3'd2;

      // Reset in the middle of a slot2 wait
      bif.addr_next = 16'h8003;
      bif.we_next   = 1'b0;
      repeat (6) step();
      chk("mw_rdy_pre", bif.cpu_rdy, 0);
      chk("mw_addr_pre", bif.bus_addr, 16'h8003);
      resb = 1'b0;
      #1;
      chk("mw_rdy", bif.cpu_rdy, 0);
      chk("mw_addr", bif.bus_addr, 16'h0000);
      chk("mw_dout", bif.bus_dout, 8'h00);
      chk("mw_we", bif.bus_we, 0);
      chk("mw_phi2", bif.phi2, 0);
      chk("mw_cs", bif.slot_cs, 4'b0000);
      repeat (2) begin
         step();
         chk("mw_hold_cs", bif.slot_cs, 4'b0000);
         chk("mw_hold_rdy", bif.cpu_rdy, 0);
      end
      resb = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("mw_restart_rdy", bif.cpu_rdy, (k == 4));
         chk("mw_restart_cs2", bif.slot_cs[2], 0);
      end

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0:       a = 16'($urandom);
            1:       a = 16'h8000 | 16'($urandom_range(0, 15));
            2:       a = 16'h8800 | 16'($urandom_range(0, 15));
            default: a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
         endcase
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < 4; i++) wt[i] = 3'($urandom_range(0, 7));
         end
         for (int i = 0; i < 4; i++) sdin[i] = 8'($urandom);
         bif.ext_din = 8'($urandom);
         do_access(a, 8'($urandom), 1'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
